// File: rtl/wr_arria10_xcvr_rst_seq.sv
// Reset sequencer for the Arria 10 transceiver reset-controller IP: holds the IP in reset,
// waits for calibration, TX ready, then RX ready plus lock, and retries on any failure.
`timescale 1ns/1ps

module wr_arria10_xcvr_rst_seq #(
    parameter int g_RST_HOLD_CYCLES = 16,
    parameter int g_READY_TIMEOUT   = 1000000,
    parameter int g_LOL_FILTER      = 8,
    parameter int g_RETRY_CNT_WIDTH = 8
) (
    input  logic                         clk_sys_i,
    input  logic                         rst_n_i,
    input  logic                         rst_req_i,
    output logic                         xcvr_rst_o,
    input  logic                         tx_cal_busy_i,
    input  logic                         rx_cal_busy_i,
    input  logic                         tx_ready_i,
    input  logic                         rx_ready_i,
    input  logic                         rx_is_lockedtodata_i,
    output logic                         tx_ready_o,
    output logic                         rx_ready_o,
    output logic                         link_up_o,
    output logic [2:0]                   state_o,
    output logic [g_RETRY_CNT_WIDTH-1:0] retry_cnt_o
);

    localparam logic [2:0] S_RESET    = 3'd0;
    localparam logic [2:0] S_WAIT_CAL = 3'd1;
    localparam logic [2:0] S_WAIT_TX  = 3'd2;
    localparam logic [2:0] S_WAIT_RX  = 3'd3;
    localparam logic [2:0] S_UP       = 3'd4;

    localparam int HOLD_W = (g_RST_HOLD_CYCLES > 1) ? $clog2(g_RST_HOLD_CYCLES) : 1;
    localparam int TMO_W  = $clog2(g_READY_TIMEOUT);
    localparam int LOL_W  = (g_LOL_FILTER > 1) ? $clog2(g_LOL_FILTER) : 1;

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(g_RST_HOLD_CYCLES - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(g_READY_TIMEOUT - 1);
    localparam logic [LOL_W-1:0]  LOL_LAST  = LOL_W'(g_LOL_FILTER - 1);
    localparam logic [g_RETRY_CNT_WIDTH-1:0] RETRY_MAX = {g_RETRY_CNT_WIDTH{1'b1}};

    logic                         lock_meta_r;
    logic                         lock_sync_r;
    logic [2:0]                   state_r;
    logic [2:0]                   prog_state_s;
    logic [2:0]                   next_state_s;
    logic                         fail_s;
    logic [HOLD_W-1:0]            hold_cnt_r;
    logic [TMO_W-1:0]             tmo_cnt_r;
    logic [LOL_W-1:0]             lol_cnt_r;
    logic [g_RETRY_CNT_WIDTH-1:0] retry_cnt_r;
    logic                         hold_done_s;
    logic                         tmo_hit_s;
    logic                         lol_hit_s;
    logic                         in_wait_s;
    logic                         xcvr_rst_s;
    logic                         tx_ready_s;
    logic                         link_up_s;
    logic                         xcvr_rst_r;
    logic                         tx_ready_r;
    logic                         link_up_r;

    assign hold_done_s = (hold_cnt_r == HOLD_LAST);
    assign tmo_hit_s   = (tmo_cnt_r == TMO_LAST);
    // The filter fires on the cycle the low run would reach g_LOL_FILTER, not one later.
    assign lol_hit_s   = !lock_sync_r && (lol_cnt_r == LOL_LAST);
    assign in_wait_s   = (state_r == S_WAIT_CAL) || (state_r == S_WAIT_TX) || (state_r == S_WAIT_RX);

    // Two-flop synchronizer for the asynchronous lock-to-data flag.
    always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            lock_meta_r <= 1'b0;
            lock_sync_r <= 1'b0;
        end else begin
            lock_meta_r <= rx_is_lockedtodata_i;
            lock_sync_r <= lock_meta_r;
        end
    end

    // FSM state register.
    always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_r <= S_RESET;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; software request and failure both override normal progress.
    always_comb begin
        prog_state_s = state_r;
        fail_s       = 1'b0;
        case (state_r)
            S_RESET: begin
                if (hold_done_s && !rst_req_i) prog_state_s = S_WAIT_CAL;
                else                           prog_state_s = S_RESET;
            end
            S_WAIT_CAL: begin
                if (!tx_cal_busy_i && !rx_cal_busy_i) prog_state_s = S_WAIT_TX;
                else if (tmo_hit_s)                  fail_s       = 1'b1;
                else                                 prog_state_s = S_WAIT_CAL;
            end
            S_WAIT_TX: begin
                if (tx_ready_i)     prog_state_s = S_WAIT_RX;
                else if (tmo_hit_s) fail_s       = 1'b1;
                else                prog_state_s = S_WAIT_TX;
            end
            S_WAIT_RX: begin
                if (!tx_ready_i)                     fail_s       = 1'b1;
                else if (rx_ready_i && lock_sync_r)  prog_state_s = S_UP;
                else if (tmo_hit_s)                  fail_s       = 1'b1;
                else                                 prog_state_s = S_WAIT_RX;
            end
            S_UP: begin
                if (!tx_ready_i || !rx_ready_i || lol_hit_s) fail_s       = 1'b1;
                else                                         prog_state_s = S_UP;
            end
            default: prog_state_s = S_RESET;
        endcase
        next_state_s = (rst_req_i || fail_s) ? S_RESET : prog_state_s;
    end

    // Output decode from the next state so registered outputs move on the transition edge.
    always_comb begin
        xcvr_rst_s = (next_state_s == S_RESET);
        tx_ready_s = (next_state_s == S_WAIT_RX) || (next_state_s == S_UP);
        link_up_s  = (next_state_s == S_UP);
    end

    // Registered status outputs.
    always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            xcvr_rst_r <= 1'b1;
            tx_ready_r <= 1'b0;
            link_up_r  <= 1'b0;
        end else begin
            xcvr_rst_r <= xcvr_rst_s;
            tx_ready_r <= tx_ready_s;
            link_up_r  <= link_up_s;
        end
    end

    // Reset hold, stage timeout and loss-of-lock run counters.
    always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            hold_cnt_r <= {HOLD_W{1'b0}};
            tmo_cnt_r  <= {TMO_W{1'b0}};
            lol_cnt_r  <= {LOL_W{1'b0}};
        end else begin
            if (state_r != S_RESET || rst_req_i) hold_cnt_r <= {HOLD_W{1'b0}};
            else if (!hold_done_s)               hold_cnt_r <= hold_cnt_r + 1'b1;
            else                                 hold_cnt_r <= hold_cnt_r;

            if (next_state_s != state_r) tmo_cnt_r <= {TMO_W{1'b0}};
            else if (in_wait_s)          tmo_cnt_r <= tmo_cnt_r + 1'b1;
            else                         tmo_cnt_r <= {TMO_W{1'b0}};

            if (state_r != S_UP || lock_sync_r) lol_cnt_r <= {LOL_W{1'b0}};
            else if (lol_cnt_r != LOL_LAST)     lol_cnt_r <= lol_cnt_r + 1'b1;
            else                                lol_cnt_r <= lol_cnt_r;
        end
    end

    // Saturating retry counter; software-requested resets are not retries.
    always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            retry_cnt_r <= {g_RETRY_CNT_WIDTH{1'b0}};
        end else if (fail_s && !rst_req_i && (retry_cnt_r != RETRY_MAX)) begin
            retry_cnt_r <= retry_cnt_r + 1'b1;
        end else begin
            retry_cnt_r <= retry_cnt_r;
        end
    end

    assign xcvr_rst_o  = xcvr_rst_r;
    assign tx_ready_o  = tx_ready_r;
    assign rx_ready_o  = link_up_r;
    assign link_up_o   = link_up_r;
    assign state_o     = state_r;
    assign retry_cnt_o = retry_cnt_r;

endmodule

// File: tb/tb_wr_arria10_xcvr_rst_seq.sv
// Bench for wr_arria10_xcvr_rst_seq: directed bring-up scenarios plus randomized link
// behaviour, all checked every cycle against a behavioural model of the sequencer.
`timescale 1ns/1ps

module tb_wr_arria10_xcvr_rst_seq;

    localparam int HOLD = 4;
    localparam int TMO  = 32;
    localparam int LOL  = 3;
    localparam int RW   = 4;
    localparam int RMAX = 15;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rst_req = 1'b0;
    logic          tx_cal_busy = 1'b0;
    logic          rx_cal_busy = 1'b0;
    logic          tx_ready_in = 1'b0;
    logic          rx_ready_in = 1'b0;
    logic          lock_in = 1'b0;
    logic          xcvr_rst;
    logic          tx_ready_out;
    logic          rx_ready_out;
    logic          link_up;
    logic [2:0]    state;
    logic [RW-1:0] retry_cnt;

    int checks = 0;
    int errors = 0;

    // Model: phase number, cycles spent in the phase, lock delay line, low-lock run, retries.
    int   m_state;
    int   m_age;
    int   m_low;
    int   m_retry;
    logic m_pipe0;
    logic m_pipe1;

    wr_arria10_xcvr_rst_seq #(
        .g_RST_HOLD_CYCLES (HOLD),
        .g_READY_TIMEOUT   (TMO),
        .g_LOL_FILTER      (LOL),
        .g_RETRY_CNT_WIDTH (RW)
    ) dut (
        .clk_sys_i            (clk),
        .rst_n_i              (rst_n),
        .rst_req_i            (rst_req),
        .xcvr_rst_o           (xcvr_rst),
        .tx_cal_busy_i        (tx_cal_busy),
        .rx_cal_busy_i        (rx_cal_busy),
        .tx_ready_i           (tx_ready_in),
        .rx_ready_i           (rx_ready_in),
        .rx_is_lockedtodata_i (lock_in),
        .tx_ready_o           (tx_ready_out),
        .rx_ready_o           (rx_ready_out),
        .link_up_o            (link_up),
        .state_o              (state),
        .retry_cnt_o          (retry_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_age   = 0;
        m_low   = 0;
        m_retry = 0;
        m_pipe0 = 1'b0;
        m_pipe1 = 1'b0;
    endtask

    // One clock edge of the behavioural model, using the inputs currently driven.
    task automatic model_step();
        logic ls;
        logic fail;
        logic go;
        int   ns;
        ls   = m_pipe1;
        fail = 1'b0;
        go   = 1'b0;
        case (m_state)
            0: go = (m_age >= HOLD - 1) && !rst_req;
            1: begin
                go   = !tx_cal_busy && !rx_cal_busy;
                fail = !go && (m_age >= TMO - 1);
            end
            2: begin
                go   = tx_ready_in;
                fail = !go && (m_age >= TMO - 1);
            end
            3: begin
                if (!tx_ready_in)             fail = 1'b1;
                else if (rx_ready_in && ls)   go   = 1'b1;
                else                          fail = (m_age >= TMO - 1);
            end
            4: fail = !tx_ready_in || !rx_ready_in || (!ls && (m_low + 1 >= LOL));
            default: ;
        endcase
        if (rst_req || fail) ns = 0;
        else if (go)         ns = m_state + 1;
        else                 ns = m_state;
        if (fail && !rst_req && m_retry < RMAX) m_retry++;
        if (m_state == 4 && !ls) m_low = (m_low + 1 < LOL) ? m_low + 1 : LOL;
        else                     m_low = 0;
        if (ns != m_state || (m_state == 0 && rst_req)) m_age = 0;
        else                                             m_age++;
        m_pipe1 = m_pipe0;
        m_pipe0 = lock_in;
        m_state = ns;
    endtask

    task automatic check_outputs();
        check_val("xcvr_rst", xcvr_rst, m_state == 0);
        check_val("tx_ready_o", tx_ready_out, m_state >= 3);
        check_val("rx_ready_o", rx_ready_out, m_state == 4);
        check_val("link_up", link_up, m_state == 4);
        check_val("state", state, m_state);
        check_val("retry_cnt", retry_cnt, m_retry);
    endtask

    // Starts and ends on a falling edge; inputs are held across the rising edge.
    task automatic tick(input logic txc, input logic rxc, input logic tx, input logic rx,
                        input logic lk, input logic req);
        tx_cal_busy = txc;
        rx_cal_busy = rxc;
        tx_ready_in = tx;
        rx_ready_in = rx;
        lock_in     = lk;
        rst_req     = req;
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        check_outputs();
        rst_n = 1'b1;
    endtask

    task automatic bring_up();
        int n;
        n = 0;
        while (!link_up && n < 100) begin
            tick(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
            n++;
        end
        check_val("bring_up", link_up, 1'b1);
    endtask

    function automatic logic evolve(input logic good);
        if (good) return ($urandom_range(0, 39) != 0);
        else      return ($urandom_range(0, 3) == 0);
    endfunction

    initial begin
        int   n;
        int   fall_at;
        logic txc_ok;
        logic rxc_ok;
        logic tx_ok;
        logic rx_ok;
        logic lk_ok;

        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_outputs();
        rst_n = 1'b1;

        // Nominal bring-up
        fall_at = 0;
        for (int i = 1; i <= 25; i++) begin
            tick(1'b0, 1'b0, i >= 10, i >= 20, i >= 20, 1'b0);
            if (!xcvr_rst && fall_at == 0) fall_at = i;
            if (i == 9)  check_val("tx_ready_early", tx_ready_out, 1'b0);
            if (i == 10) check_val("tx_ready_lat", tx_ready_out, 1'b1);
            if (i == 21) check_val("link_up_early", link_up, 1'b0);
            if (i == 22) check_val("link_up_lat", link_up, 1'b1);
        end
        check_val("rst_hold_edges", fall_at, HOLD);
        check_val("nominal_retry", retry_cnt, 0);

        // TX timeout, twice
        async_reset();
        for (int r = 1; r <= 2; r++) begin
            n = 0;
            while (state != 3'd2 && n < 60) begin
                tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
                n++;
            end
            check_val("tmo_enter", state, 2);
            n = 0;
            while (!xcvr_rst && n < 60) begin
                tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
                n++;
            end
            check_val("tmo_latency", n, TMO);
            check_val("tmo_retry", retry_cnt, r);
        end

        // Loss-of-lock filter: short glitch tolerated, full run drops the link
        bring_up();
        repeat (3) tick(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        repeat (2) tick(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        repeat (6) tick(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        check_val("lol_glitch", link_up, 1'b1);
        fall_at = 0;
        for (int k = 1; k <= 10; k++) begin
            tick(1'b0, 1'b0, 1'b1, 1'b1, k > 3, 1'b0);
            if (!link_up && fall_at == 0) fall_at = k;
        end
        check_val("lol_latency", fall_at, 2 + LOL);
        check_val("lol_retry", retry_cnt, 3);

        // Software request in S_UP
        bring_up();
        for (int k = 0; k < 6; k++) begin
            tick(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
            if (k == 0) check_val("req_rst_asserts", xcvr_rst, 1'b1);
        end
        n = 0;
        do begin
            tick(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
            n++;
        end while (xcvr_rst && n < 20);
        check_val("req_release_edges", n, HOLD);
        check_val("req_retry", retry_cnt, 3);

        // Saturation after 20 consecutive calibration timeouts
        repeat (20 * (HOLD + TMO) + 10) tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check_val("retry_saturate", retry_cnt, RMAX);

        // Asynchronous reset while waiting for RX
        n = 0;
        while (state != 3'd3 && n < 60) begin
            tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
            n++;
        end
        check_val("wait_rx_reached", state, 3);
        async_reset();
        check_val("async_retry_clear", retry_cnt, 0);

        // Randomized link behaviour
        txc_ok = 1'b1;
        rxc_ok = 1'b1;
        tx_ok  = 1'b1;
        rx_ok  = 1'b1;
        lk_ok  = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            txc_ok = evolve(txc_ok);
            rxc_ok = evolve(rxc_ok);
            tx_ok  = evolve(tx_ok);
            rx_ok  = evolve(rx_ok);
            lk_ok  = evolve(lk_ok);
            tick(!txc_ok, !rxc_ok, tx_ok, rx_ok, lk_ok, $urandom_range(0, 63) == 0);
            if ($urandom_range(0, 499) == 0) async_reset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wr_arria10_xcvr_rst_seq.md
# wr_arria10_xcvr_rst_seq

Sequencer that owns the reset input of the Arria 10 transceiver reset-controller IP and brings the WR PHY link up in order. It reads the IP status, checks that calibration has finished, and waits for TX then RX readiness, with a timeout at each stage. Once the link is up it watches for loss of lock. On any failure it re-resets the IP and counts the retry. It sits between the WR PHY wrapper (status/software reset request) and the reset-controller IP instance, in the IP's `clock` domain.

## Interface
Parameters:
- `g_RST_HOLD_CYCLES`, 16: cycles `xcvr_rst_o` is held high per reset attempt (≥1).
- `g_READY_TIMEOUT`, 1000000: maximum cycles allowed in each wait state before a retry (≥2).
- `g_LOL_FILTER`, 8: consecutive cycles of synchronized lock-low needed to declare loss of lock (≥1).
- `g_RETRY_CNT_WIDTH`, 8: width of the retry counter.

Ports:
- `clk_sys_i` in 1: single clock, the same clock fed to the reset-controller IP `clock`.
- `rst_n_i` in 1: asynchronous, active-low reset.
- `rst_req_i` in 1: level reset request from the PHY wrapper or software, synchronous to `clk_sys_i`.
- `xcvr_rst_o` out 1: drives the IP `reset`, active high.
- `tx_cal_busy_i` in 1: from the IP, synchronous.
- `rx_cal_busy_i` in 1: from the IP, synchronous.
- `tx_ready_i` in 1: IP `tx_ready`, synchronous.
- `rx_ready_i` in 1: IP `rx_ready`, synchronous.
- `rx_is_lockedtodata_i` in 1: from the transceiver, asynchronous. A 2-FF synchronizer is applied internally.
- `tx_ready_o` out 1: TX path usable.
- `rx_ready_o` out 1: RX path usable.
- `link_up_o` out 1: full link up.
- `state_o` out 3: current FSM state encoding.
- `retry_cnt_o` out `g_RETRY_CNT_WIDTH`: saturating count of failure-triggered retries.

## Operation
State encoding:
- S_RESET = 0
- S_WAIT_CAL = 1
- S_WAIT_TX = 2
- S_WAIT_RX = 3
- S_UP = 4

Values 5–7 are unused and go to S_RESET on the next cycle.

Per-state behaviour:
- **S_RESET:** `xcvr_rst_o` = 1. The hold counter increments from 0. When it reaches `g_RST_HOLD_CYCLES`-1 and `rst_req_i` = 0, go to S_WAIT_CAL. While `rst_req_i` = 1 the hold counter stays at 0.
- **S_WAIT_CAL:** Go to S_WAIT_TX when `tx_cal_busy_i` = 0 and `rx_cal_busy_i` = 0.
- **S_WAIT_TX:** Go to S_WAIT_RX when `tx_ready_i` = 1.
- **S_WAIT_RX:** Go to S_UP when `rx_ready_i` = 1 and synchronized lock = 1. If `tx_ready_i` drops, it is a failure.
- **S_UP:** Any of the following is a failure:
  - `tx_ready_i` = 0
  - `rx_ready_i` = 0
  - the loss-of-lock filter count reaches `g_LOL_FILTER`

Timeout:
- One timeout counter, cleared on every state change.
- It counts in S_WAIT_CAL, S_WAIT_TX and S_WAIT_RX.
- Reaching `g_READY_TIMEOUT`-1 is a failure.

Failure handling:
- Next state is S_RESET and `retry_cnt_o` increments.
- `retry_cnt_o` saturates at all-ones and is cleared only by `rst_n_i`.

Software reset:
- `rst_req_i` = 1 in any state forces S_RESET on the next cycle.
- It takes priority over failure and normal progress in the same cycle.
- It does not increment `retry_cnt_o`.

Loss-of-lock filter:
- It counts consecutive cycles with synchronized lock = 0 while in S_UP.
- It clears when lock = 1 or when outside S_UP.

Output decode (all outputs registered):
- `xcvr_rst_o` = (state == S_RESET).
- `tx_ready_o` = state ∈ {S_WAIT_RX, S_UP}.
- `rx_ready_o` = `link_up_o` = (state == S_UP).

## Timing
Reset values while `rst_n_i` = 0:
- state = S_RESET, `xcvr_rst_o` = 1.
- `tx_ready_o`, `rx_ready_o`, `link_up_o` = 0.
- `state_o` = 0, `retry_cnt_o` = 0.
- All internal counters and synchronizer flops = 0.

Latencies:
- After `rst_n_i` deassertion with `rst_req_i` = 0, `xcvr_rst_o` stays high for exactly `g_RST_HOLD_CYCLES` rising edges.
- Each state transition takes effect on the edge after its condition is sampled. Outputs follow the same edge.
- Lock input to FSM: 2 cycles of synchronizer latency.
- Loss of lock to `link_up_o` = 0 and `xcvr_rst_o` = 1: 2 + `g_LOL_FILTER` cycles after lock falls.
- `tx_ready_i`/`rx_ready_i` drop in S_UP to `xcvr_rst_o` = 1: 1 cycle.

Boundary conditions:
- Timeout and the progress condition in the same cycle: progress wins.
- Failure and `rst_req_i` together: S_RESET is entered, retry is not counted.
- Asserting `rst_n_i` mid-sequence returns every output to its reset value immediately (asynchronously).

## Test plan
Parameters for all tests: HOLD = 4, TIMEOUT = 32, LOL = 3, RETRY width 4.
1. **Nominal bring-up.** Release reset, cal busy low, `tx_ready_i` at cycle 10, `rx_ready_i` + lock at cycle 20. Expect:
   - `xcvr_rst_o` high for exactly 4 cycles.
   - `tx_ready_o` 1 cycle after `tx_ready_i`.
   - `link_up_o` 1 cycle after the synchronized lock/`rx_ready_i` condition is seen.
   - `retry_cnt_o` = 0.
2. **TX timeout.** Hold `tx_ready_i` = 0. Expect:
   - `xcvr_rst_o` reasserts 32 cycles after entering S_WAIT_TX.
   - `retry_cnt_o` = 1, then 2 on the next attempt.
3. **Loss-of-lock filter.** In S_UP:
   - A lock-low glitch of 2 cycles leaves `link_up_o` = 1.
   - A 3-cycle low drops `link_up_o` 5 cycles after the fall, and `retry_cnt_o` increments.
4. **Software request.** Pulse `rst_req_i` for 6 cycles in S_UP. Expect:
   - `xcvr_rst_o` high from the next cycle until 4 cycles after `rst_req_i` falls.
   - `retry_cnt_o` unchanged.
5. **Saturation.** Force 20 consecutive timeouts. Expect `retry_cnt_o` to stick at 15.
6. **Async reset mid-sequence.** Assert `rst_n_i` during S_WAIT_RX. Expect all outputs to reach their reset values without a clock edge.
